cv32e40p_ex_wb_arbiter: RTL and testbench
=========================================

Name: cv32e40p_ex_wb_arbiter

Overview:
- Arbitrates the EX-stage ALU/MUL register-file write port between the ALU/MUL result and APU (FPU) results, which arrive without backpressure.
- Buffers APU results that lose arbitration in a small in-order FIFO.
- Applies APU-first priority, with an anti-starvation counter that guarantees ALU/MUL progress.
- Sits between the EX stage result muxing and the ID-stage register file; exports stall and dependency hints to the decoder.

Parameters:
APU_FIFO_DEPTH, 2, APU result buffer entries (>=2)
MAX_ALU_WAIT, 4, consecutive denied ALU cycles before ALU is forced a grant (>=1)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
alu_valid_i  input  1  ALU/MUL result valid, held stable until accepted
alu_waddr_i  input  6  ALU/MUL destination register
alu_wdata_i  input  32  ALU/MUL result
alu_ready_o  output  1  ALU/MUL result accepted this cycle (combinational)
apu_rvalid_i  input  1  APU result valid, single-cycle pulse, no backpressure
apu_waddr_i  input  6  APU destination register
apu_wdata_i  input  32  APU result
apu_stall_o  output  1  block new APU issue; FIFO near full
dep_raddr_i  input  6  decoder operand address for the dependency check
apu_dep_hit_o  output  1  dep_raddr_i matches a buffered or arriving APU waddr
wb_we_o  output  1  registered write enable
wb_waddr_o  output  6  registered write address
wb_wdata_o  output  32  registered write data
wb_src_o  output  1  0 = ALU/MUL, 1 = APU
overflow_o  output  1  sticky: APU result dropped

Behaviour:
- Reset values: all registered outputs, FIFO count, pointers, wait_cnt and overflow_o are 0.
- Reset applied mid-operation discards FIFO contents and in-flight grants; wb_we_o = 0 in the next cycle.
- Synchronous reset only: reset is sampled on clk_i and has no asynchronous path.
- APU candidate selection:
  - FIFO head when count > 0.
  - Otherwise apu_rvalid_i bypass.
  - A new arrival never overtakes buffered entries; APU results stay in order.
- Grant rules:
  - Only ALU valid: grant ALU.
  - Only APU candidate: grant APU.
  - Both valid: grant APU unless wait_cnt == MAX_ALU_WAIT, in which case grant ALU.
- alu_ready_o = alu_valid_i & grant_alu.
- wait_cnt:
  - Increments, saturating at MAX_ALU_WAIT, when alu_valid_i & !grant_alu.
  - Clears when ALU is granted or alu_valid_i = 0.
- Write-back latency is 1 cycle. Granted source's waddr/wdata/src are registered into wb_*; wb_we_o = 1 the cycle after the grant, else 0.
- FIFO push: apu_rvalid_i and the arrival was not granted by bypass.
- FIFO pop: head granted.
- Push and pop may occur in the same cycle: count unchanged, order preserved.
- Push is accepted when count < DEPTH, or when count == DEPTH and a pop occurs the same cycle.
- Push with count == DEPTH and no pop: the result is dropped, overflow_o is set to 1 and held until reset, FIFO is unchanged.
- Pointers wrap modulo APU_FIFO_DEPTH.
- apu_stall_o = (count >= APU_FIFO_DEPTH-1), combinational from the registered count.
- apu_dep_hit_o (combinational) is 1 when either:
  - any valid FIFO entry's waddr == dep_raddr_i, or
  - apu_rvalid_i & apu_waddr_i == dep_raddr_i.
- Same-register conflict (ALU and APU targeting the same waddr) is not resolved here; write order follows grant order.

Test Plan:
- ALU only: alu_valid_i = 1, waddr = 5, wdata = 0x1234 -> alu_ready_o = 1 same cycle; next cycle wb_we_o = 1, wb_waddr_o = 5, wb_wdata_o = 0x1234, wb_src_o = 0.
- Collision: alu_valid_i = 1 (waddr 3) and apu_rvalid_i (waddr 7, 0xAA) in the same cycle, FIFO empty -> APU bypass granted, alu_ready_o = 0; the following cycle the ALU is granted; wb sequence is 7 then 3.
- Starvation: alu_valid_i held high while an APU result arrives every cycle (stall ignored), MAX_ALU_WAIT = 4 -> ALU denied 4 cycles, granted on the 5th; wait_cnt returns to 0.
- Ordering and full: 3 APU pulses (waddr 1, 2, 3) while the ALU is forced-granted, DEPTH = 2 -> apu_stall_o = 1 at count 1; the third pulse coincides with a pop and is accepted; wb order is 1, 2, 3; overflow_o stays 0.
- Overflow: FIFO full with no pop and a 4th pulse arrives -> result dropped, overflow_o = 1 held until rst_i.
- Dependency and reset: FIFO holds waddr 9, dep_raddr_i = 9 -> apu_dep_hit_o = 1; assert rst_i for 1 cycle -> count = 0, apu_dep_hit_o = 0, wb_we_o = 0, overflow_o = 0.

Source files
------------

// File: rtl/cv32e40p_ex_wb_arbiter.sv
// EX write-port arbiter: APU-first with ALU anti-starvation, losing APU results held in an in-order FIFO.
// Write-back registered 1 cycle after grant; ALU waits on alu_ready_o, APU has no backpressure (stall hint, sticky drop flag).
module cv32e40p_ex_wb_arbiter #(
    parameter int APU_FIFO_DEPTH = 2,
    parameter int MAX_ALU_WAIT   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        alu_valid_i,
    input  logic [5:0]  alu_waddr_i,
    input  logic [31:0] alu_wdata_i,
    output logic        alu_ready_o,
    input  logic        apu_rvalid_i,
    input  logic [5:0]  apu_waddr_i,
    input  logic [31:0] apu_wdata_i,
    output logic        apu_stall_o,
    input  logic [5:0]  dep_raddr_i,
    output logic        apu_dep_hit_o,
    output logic        wb_we_o,
    output logic [5:0]  wb_waddr_o,
    output logic [31:0] wb_wdata_o,
    output logic        wb_src_o,
    output logic        overflow_o
);

    localparam int PW = $clog2(APU_FIFO_DEPTH);
    localparam int CW = $clog2(APU_FIFO_DEPTH + 1);
    localparam int WW = $clog2(MAX_ALU_WAIT + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(APU_FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(APU_FIFO_DEPTH - 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_ALU_WAIT);

    typedef struct packed {
        logic [5:0]  waddr;
        logic [31:0] wdata;
    } apu_res_t;

    apu_res_t                  fifo_mem [APU_FIFO_DEPTH];
    logic [APU_FIFO_DEPTH-1:0] entry_vld;
    logic [PW-1:0]             rd_ptr;
    logic [PW-1:0]             wr_ptr;
    logic [CW-1:0]             count;
    logic [WW-1:0]             wait_cnt;

    logic     fifo_nonempty;
    logic     fifo_full;
    logic     apu_cand_vld;
    apu_res_t apu_cand;
    logic     grant_alu;
    logic     grant_apu;
    logic     fifo_pop;
    logic     apu_bypass;
    logic     push_req;
    logic     fifo_push;
    logic     apu_drop;

    // Buffered entries always win over a fresh arrival so APU results retire in order.
    assign fifo_nonempty = (count != '0);
    assign fifo_full     = (count == DEPTH_C);
    assign apu_cand_vld  = fifo_nonempty | apu_rvalid_i;
    assign apu_cand      = fifo_nonempty ? fifo_mem[rd_ptr] : apu_res_t'({apu_waddr_i, apu_wdata_i});

    assign grant_alu  = alu_valid_i & (~apu_cand_vld | (wait_cnt == WAIT_MAX));
    assign grant_apu  = apu_cand_vld & ~grant_alu;
    assign fifo_pop   = grant_apu & fifo_nonempty;
    assign apu_bypass = grant_apu & ~fifo_nonempty;
    assign push_req   = apu_rvalid_i & ~apu_bypass;
    assign fifo_push  = push_req & (~fifo_full | fifo_pop);
    assign apu_drop   = push_req & fifo_full & ~fifo_pop;

    assign alu_ready_o = alu_valid_i & grant_alu;
    assign apu_stall_o = (count >= (DEPTH_C - CW'(1)));

    always_comb begin
        apu_dep_hit_o = apu_rvalid_i & (apu_waddr_i == dep_raddr_i);
        for (int i = 0; i < APU_FIFO_DEPTH; i++) begin
            if (entry_vld[i] && (fifo_mem[i].waddr == dep_raddr_i)) begin
                apu_dep_hit_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= apu_res_t'({apu_waddr_i, apu_wdata_i});
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            entry_vld  <= '0;
            overflow_o <= 1'b0;
        end else begin
            // On a full-FIFO push+pop both pointers match; the set below must win over the clear.
            if (fifo_pop) begin
                entry_vld[rd_ptr] <= 1'b0;
                rd_ptr            <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            end
            if (fifo_push) begin
                entry_vld[wr_ptr] <= 1'b1;
                wr_ptr            <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (apu_drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
        end else if (alu_valid_i && !grant_alu) begin
            wait_cnt <= (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_we_o    <= 1'b0;
            wb_waddr_o <= '0;
            wb_wdata_o <= '0;
            wb_src_o   <= 1'b0;
        end else begin
            wb_we_o <= grant_alu | grant_apu;
            if (grant_alu) begin
                wb_waddr_o <= alu_waddr_i;
                wb_wdata_o <= alu_wdata_i;
                wb_src_o   <= 1'b0;
            end else if (grant_apu) begin
                wb_waddr_o <= apu_cand.waddr;
                wb_wdata_o <= apu_cand.wdata;
                wb_src_o   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_ex_wb_arbiter.sv
// Randomized bench: queue-based reference model feeds an expected write-back scoreboard, checked by a separate monitor.
module tb_cv32e40p_ex_wb_arbiter;

    localparam int D    = 2;
    localparam int MAXW = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alu_valid_i;
    logic [5:0]  alu_waddr_i;
    logic [31:0] alu_wdata_i;
    logic        alu_ready_o;
    logic        apu_rvalid_i;
    logic [5:0]  apu_waddr_i;
    logic [31:0] apu_wdata_i;
    logic        apu_stall_o;
    logic [5:0]  dep_raddr_i;
    logic        apu_dep_hit_o;
    logic        wb_we_o;
    logic [5:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic        wb_src_o;
    logic        overflow_o;

    cv32e40p_ex_wb_arbiter #(.APU_FIFO_DEPTH(D), .MAX_ALU_WAIT(MAXW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alu_valid_i(alu_valid_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
        .alu_ready_o(alu_ready_o),
        .apu_rvalid_i(apu_rvalid_i), .apu_waddr_i(apu_waddr_i), .apu_wdata_i(apu_wdata_i),
        .apu_stall_o(apu_stall_o), .dep_raddr_i(dep_raddr_i), .apu_dep_hit_o(apu_dep_hit_o),
        .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
        .wb_src_o(wb_src_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        src;
        logic [5:0]  a;
        logic [31:0] d;
    } wb_t;

    wb_t exp_q[$];
    wb_t apu_q[$];
    int  wait_m;
    bit  ovf_m;
    bit  alu_acc;
    int  n_cmp;
    int  n_fail;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the APU side is a plain queue; one call per clock with inputs stable.
    task automatic model_step();
        bit cand, g_alu, g_apu, dep;
        wb_t arr;
        alu_acc = 1'b0;
        if (rst_i) begin
            apu_q.delete();
            wait_m = 0;
            ovf_m  = 1'b0;
            return;
        end
        arr   = {1'b1, apu_waddr_i, apu_wdata_i};
        cand  = (apu_q.size() > 0) || apu_rvalid_i;
        g_alu = alu_valid_i && (!cand || wait_m == MAXW);
        g_apu = cand && !g_alu;
        dep   = apu_rvalid_i && (apu_waddr_i == dep_raddr_i);
        foreach (apu_q[i]) if (apu_q[i].a == dep_raddr_i) dep = 1'b1;

        chk("alu_ready", alu_ready_o, g_alu);
        chk("apu_stall", apu_stall_o, apu_q.size() >= D - 1);
        chk("dep_hit", apu_dep_hit_o, dep);
        chk("overflow", overflow_o, ovf_m);

        if (g_alu) begin
            exp_q.push_back({1'b0, alu_waddr_i, alu_wdata_i});
            alu_acc = 1'b1;
        end
        if (g_apu && apu_q.size() > 0) begin
            exp_q.push_back(apu_q.pop_front());
            if (apu_rvalid_i) apu_q.push_back(arr);
        end else if (g_apu) begin
            exp_q.push_back(arr);
        end else if (apu_rvalid_i) begin
            if (apu_q.size() < D) apu_q.push_back(arr);
            else ovf_m = 1'b1;
        end
        if (alu_valid_i && !g_alu) wait_m = (wait_m < MAXW) ? wait_m + 1 : MAXW;
        else wait_m = 0;
    endtask

    task automatic step();
        @(negedge clk_i);
        model_step();
        @(posedge clk_i);
        #1;
        if (alu_acc) alu_valid_i = 1'b0;
        apu_rvalid_i = 1'b0;
    endtask

    task automatic new_alu(input logic [5:0] a, input logic [31:0] d);
        alu_valid_i = 1'b1;
        alu_waddr_i = a;
        alu_wdata_i = d;
    endtask

    task automatic apu_pulse(input logic [5:0] a, input logic [31:0] d);
        apu_rvalid_i = 1'b1;
        apu_waddr_i  = a;
        apu_wdata_i  = d;
    endtask

    // Monitor: every registered write must match the oldest expected write, in order.
    initial begin
        wb_t e;
        bit  expv;
        forever begin
            @(posedge clk_i);
            #2;
            expv = (exp_q.size() != 0);
            chk("wb_we", wb_we_o, expv);
            if (expv) begin
                e = exp_q.pop_front();
                if (wb_we_o) begin
                    chk("wb_src", wb_src_o, e.src);
                    chk("wb_waddr", wb_waddr_o, e.a);
                    chk("wb_wdata", wb_wdata_o, e.d);
                end
            end
        end
    end

    initial begin
        n_cmp = 0; n_fail = 0; wait_m = 0; ovf_m = 1'b0; alu_acc = 1'b0;
        rst_i = 1'b1; alu_valid_i = 1'b0; alu_waddr_i = '0; alu_wdata_i = '0;
        apu_rvalid_i = 1'b0; apu_waddr_i = '0; apu_wdata_i = '0; dep_raddr_i = '0;
        repeat (3) step();
        rst_i = 1'b0;
        chk("rst_wb_we", wb_we_o, 0);
        chk("rst_overflow", overflow_o, 0);
        chk("rst_stall", apu_stall_o, 0);
        chk("rst_dep_hit", apu_dep_hit_o, 0);

        new_alu(6'd5, 32'h1234);
        step();
        new_alu(6'd3, 32'h33);
        apu_pulse(6'd7, 32'hAA);
        step();
        step();
        repeat (2) step();

        // ALU kept busy while the APU fires every cycle: forced grants fill the FIFO until it drops.
        for (int i = 0; i < 20; i++) begin
            if (!alu_valid_i) new_alu(6'(10 + (i % 8)), 32'(i));
            apu_pulse(6'(20 + (i % 16)), 32'h100 + 32'(i));
            dep_raddr_i = 6'(20 + ((i + 1) % 16));
            step();
        end
        alu_valid_i = 1'b0;
        repeat (4) step();
        chk("ovf_sticky", overflow_o, 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("ovf_cleared", overflow_o, 0);
        chk("stall_cleared", apu_stall_o, 0);

        for (int i = 0; i < 3000; i++) begin
            rst_i = ($urandom_range(0, 199) == 0);
            if (!alu_valid_i && $urandom_range(0, 2) != 0)
                new_alu(6'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 9) < 4 && (apu_q.size() < D - 1 || $urandom_range(0, 4) == 0))
                apu_pulse(6'($urandom_range(0, 15)), $urandom);
            dep_raddr_i = 6'($urandom_range(0, 15));
            step();
        end
        rst_i = 1'b0;
        alu_valid_i = 1'b0;
        repeat (6) step();
        chk("drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
